// File: rtl/mem_check_pkg.sv
// mem_check_pkg
// Shared type definitions for the memory write checker.
//   chk_state_e : checker FSM states (RUN plus the three sticky terminal states)
//   wr_class_e  : classification of a single data-memory write
package mem_check_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2,
    TMO  = 2'd3
  } chk_state_e;

  typedef enum logic [1:0] {
    MATCH  = 2'd0,
    IGNORE = 2'd1,
    UNEXP  = 2'd2
  } wr_class_e;

endpackage

// File: rtl/mem_write_classify.sv
// mem_write_classify
// Purely combinational classifier for one data-memory write.
// Ports:
//   addr, data         : the write being observed
//   exp_addr, exp_data : the expected pair currently being waited for
//   ign_lo, ign_hi     : inclusive ignored address window (lo > hi = empty)
//   wclass             : MATCH, IGNORE or UNEXP, in that priority order
module mem_write_classify
  import mem_check_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  input  logic [AW-1:0] ign_lo,
  input  logic [AW-1:0] ign_hi,
  output wr_class_e     wclass
);

  // A match needs both address and data; an address hit with wrong data
  // falls through to the window test and otherwise counts as unexpected.
  // An inverted window (lo > hi) can never satisfy both bounds, so it
  // naturally means "no window".
  always_comb begin
    wclass = UNEXP;
    if (addr == exp_addr && data == exp_data) begin
      wclass = MATCH;
    end else if (addr >= ign_lo && addr <= ign_hi) begin
      wclass = IGNORE;
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker
// Watches the data-memory write port and checks that N_EXP expected writes
// occur in order, optionally failing on any other non-ignored write, with an
// optional cycle timeout. All status outputs come from registers.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   en                  : check enable (low = writes not evaluated, counter holds)
//   memwrite            : write strobe, one write per high cycle
//   dataadr, writedata  : write address / data
//   exp_addr, exp_data  : packed expected pairs, entry k at [k*W +: W]
//   ign_lo, ign_hi      : inclusive ignored address window
//   done/pass/fail/timeout : terminal status (one-hot flags, done = any)
//   match_cnt           : expected writes matched so far
//   fail_addr/fail_data : captured offending write
//   cyc_cnt             : enabled RUN cycles, saturating
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int N_EXP       = 2,
  parameter int STRICT      = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       memwrite,
  input  logic [AW-1:0]              dataadr,
  input  logic [DW-1:0]              writedata,
  input  logic [N_EXP*AW-1:0]        exp_addr,
  input  logic [N_EXP*DW-1:0]        exp_data,
  input  logic [AW-1:0]              ign_lo,
  input  logic [AW-1:0]              ign_hi,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(N_EXP+1)-1:0] match_cnt,
  output logic [AW-1:0]              fail_addr,
  output logic [DW-1:0]              fail_data,
  output logic [31:0]                cyc_cnt
);

  localparam int CW = $clog2(N_EXP+1);

  chk_state_e    state;
  chk_state_e    state_nxt;
  wr_class_e     wclass;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          wr_eval;
  logic          take_match;
  logic          take_fail;
  logic          last_match;
  logic          tmo_hit;

  // The number of matches so far doubles as the index of the next expected
  // entry. Once all entries match the FSM leaves RUN, so the out-of-range
  // value N_EXP never has to select anything meaningful.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_EXP; k++) begin
      if (match_cnt == CW'(k)) begin
        sel_addr = exp_addr[k*AW +: AW];
        sel_data = exp_data[k*DW +: DW];
      end
    end
  end

  mem_write_classify #(
    .AW(AW),
    .DW(DW)
  ) u_classify (
    .addr     (dataadr),
    .data     (writedata),
    .exp_addr (sel_addr),
    .exp_data (sel_data),
    .ign_lo   (ign_lo),
    .ign_hi   (ign_hi),
    .wclass   (wclass)
  );

  assign wr_eval    = (state == RUN) && en && memwrite;
  assign take_match = wr_eval && (wclass == MATCH);
  assign take_fail  = wr_eval && (wclass == UNEXP) && (STRICT != 0);
  assign last_match = take_match && (match_cnt == CW'(N_EXP-1));
  assign tmo_hit    = (TIMEOUT_CYC != 0) && (state == RUN) && en &&
                      (cyc_cnt == 32'(TIMEOUT_CYC-1));

  // Next-state logic. PASS/FAIL are tested before the timeout so a verdict
  // landing on the timeout cycle wins. Terminal states hold until reset.
  always_comb begin
    state_nxt = state;
    if (state == RUN) begin
      if (last_match) begin
        state_nxt = PASS;
      end else if (take_fail) begin
        state_nxt = FAIL;
      end else if (tmo_hit) begin
        state_nxt = TMO;
      end
    end
  end

  // State and datapath registers. Reset overrides any write arriving on the
  // same edge. The cycle counter only advances in enabled RUN cycles and
  // sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      match_cnt <= '0;
      cyc_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state <= state_nxt;
      if (take_match) begin
        match_cnt <= match_cnt + 1'b1;
      end
      if (take_fail) begin
        fail_addr <= dataadr;
        fail_data <= writedata;
      end
      if (state == RUN && en && cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
    end
  end

  // Status flags decode straight from the state register, so they are
  // one-hot by construction and change exactly one edge after the cause.
  assign pass    = (state == PASS);
  assign fail    = (state == FAIL);
  assign timeout = (state == TMO);
  assign done    = pass | fail | timeout;

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter AW, default 32: data-memory address width.
REQ-002 Parameter DW, default 32: write-data width.
REQ-003 Parameter N_EXP, default 2, range 1..16: number of expected writes, checked in order.
REQ-004 Parameter STRICT, default 1: 1 = an unexpected, non-ignored write is a failure; 0 = such writes are skipped.
REQ-005 Parameter TIMEOUT_CYC, default 4096: run cycles allowed before timeout; 0 disables timeout.
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 en  in  1  check enable; when low, writes are not evaluated and the cycle counter holds.
REQ-009 memwrite  in  1  data-memory write strobe, one write per high cycle.
REQ-010 dataadr  in  AW  write address.
REQ-011 writedata  in  DW  write data.
REQ-012 exp_addr  in  N_EXP*AW  expected addresses, entry k at bits [k*AW +: AW]; held static while running.
REQ-013 exp_data  in  N_EXP*DW  expected data, same packing as exp_addr.
REQ-014 ign_lo, ign_hi  in  AW each  inclusive ignored address window; ign_lo > ign_hi means no window.
REQ-015 done  out  1  high in any terminal state.
REQ-016 pass  out  1  all N_EXP writes matched.
REQ-017 fail  out  1  strict mismatch detected.
REQ-018 timeout  out  1  TIMEOUT_CYC reached before pass or fail.
REQ-019 match_cnt  out  $clog2(N_EXP+1)  number of expected writes matched so far.
REQ-020 fail_addr, fail_data  out  AW, DW  captured offending write.
REQ-021 cyc_cnt  out  32  enabled cycles spent in RUN, saturating at all-ones.

Function
REQ-022 The FSM SHALL have states RUN, PASS, FAIL and TMO; PASS, FAIL and TMO are terminal and sticky until reset.
REQ-023 In RUN with en=1 and memwrite=1, a write SHALL be classified in this priority order: match (dataadr==exp_addr[idx] and writedata==exp_data[idx]), ignored (ign_lo<=dataadr<=ign_hi), then unexpected.
REQ-024 On a match: idx and match_cnt SHALL increment; if the matched entry is N_EXP-1, the FSM SHALL go to PASS on the same edge.
REQ-025 An address match with a data mismatch SHALL count as unexpected.
REQ-026 On an unexpected write with STRICT=1: go to FAIL and capture dataadr/writedata into fail_addr/fail_data on that edge; with STRICT=0: no state change.
REQ-027 Ignored writes SHALL have no effect other than on cyc_cnt.
REQ-028 cyc_cnt SHALL increment on each RUN cycle with en=1.
REQ-029 When TIMEOUT_CYC != 0 and cyc_cnt reaches TIMEOUT_CYC-1 in an enabled RUN cycle with no PASS/FAIL transition, the FSM SHALL go to TMO.
REQ-030 If pass/fail and timeout conditions fall on the same cycle, PASS or FAIL SHALL win.
REQ-031 Outputs SHALL be registered, with exactly one edge of latency from the write to its status update; the terminal flags SHALL be one-hot and done = pass|fail|timeout.
REQ-032 Terminal states SHALL ignore all inputs except reset.

Reset
REQ-033 reset=1 SHALL force RUN, idx=0, match_cnt=0, cyc_cnt=0, fail_addr=0, fail_data=0 and done/pass/fail/timeout=0, taking priority over every other input including an in-flight write.
REQ-034 Asserting reset mid-run or in a terminal state SHALL restart the check from entry 0 on the next cycle.

Structure
REQ-035 A shared package mem_check_pkg SHALL hold the state enum (RUN, PASS, FAIL, TMO) and the write-class enum (MATCH, IGNORE, UNEXP).
REQ-036 The classification SHALL live in a combinational sub-module mem_write_classify (inputs: address, data, selected expected pair, window; output: class); all state stays in mem_write_checker.

Verification
REQ-037 N_EXP=1, exp=(84,7), window 80..80: write (80,5) then (84,7) -> match_cnt 0 then 1, pass=1 one edge after the second write.
REQ-038 N_EXP=1, exp=(84,7), STRICT=1: write (88,1) -> fail=1, fail_addr=88, fail_data=1; a later write of (84,7) leaves pass=0.
REQ-039 N_EXP=2, exp=(60,3),(84,7): write (84,7) first with STRICT=1 -> fail; same sequence with STRICT=0, then (60,3),(84,7) -> pass.
REQ-040 TIMEOUT_CYC=10 with no writes -> timeout=1 after 10 enabled cycles; en held low for 5 of those cycles delays timeout by 5.
REQ-041 A matching final write on the timeout cycle -> pass=1, timeout=0.
REQ-042 reset pulsed for 1 cycle after match_cnt=1 and again in FAIL -> all outputs zero, then (60,3),(84,7) -> pass.
